// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner with frame-coherent shadow data and anti-ghosting guard.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros (digit 0 and dp-marked digits excepted).
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] dig_sh_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q, en_sh_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   lz_blank;

  function automatic state_t slot_state(input logic [PW-1:0] p);
    return (int'(p) < BLANK_CYCLES) ? GUARD : SHOW;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; the run of blanking stops at the first non-zero or dp digit.
  always_comb begin
    logic run;
    lz_blank = '0;
    run      = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      run         = run & (dig_sh_q[4*i +: 4] == 4'h0) & ~dp_sh_q[i];
      lz_blank[i] = run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_nib = dig_sh_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    load    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      presc_d = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      load    = 1'b1;
      presc_d = '0;
      idx_d   = '0;
      state_d = slot_state('0);
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          load  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
      state_d = slot_state(presc_d);
    end
  end

  // Outputs are computed from the current state, so they lag the counters by one cycle.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_q == SHOW && en_sh_q[idx_q] && !lz_blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex7(cur_nib);
      dp_d        = ~dp_sh_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      idx_q    <= '0;
      dig_sh_q <= '0;
      dp_sh_q  <= '0;
      en_sh_q  <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (load) begin
        dig_sh_q <= digits_in;
        dp_sh_q  <= dp_in;
        en_sh_q  <= digit_en;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign scan_idx   = idx_q;
  assign frame_done = (state_q != IDLE) && (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 8-cycle slots, 2-cycle guard): per-cycle scoreboard plus vector table.
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  scan_idx;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .an(an), .seg(seg), .dp(dp), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       fd;
  } obs_t;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpi;
    logic [3:0]  en;
    logic [15:0] an_x;
    logic [27:0] seg_x;
    logic [3:0]  dp_x;
  } vec_t;

  obs_t        sbq[$];
  vec_t        vecs[7];
  logic [6:0]  DEC[16];
  int          n_total = 0;
  int          n_bad = 0;
  int          pos = 0;
  logic        m_act = 1'b0;
  int          m_t = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;

  function automatic logic lz_model(int k);
`ifdef LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int j = 0; j < ND; j++)
      if (m_dig[4*j +: 4] != 4'h0 || m_dp[j]) msd = j;
    return k > msd;
`else
    return (k < 0);
`endif
  endfunction

  task automatic model_step();
    obs_t e;
    int   k;
    e.an  = '1;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (m_act && (m_t % RD) >= BC) begin
      k = (m_t / RD) % ND;
      if (m_en[k] && !lz_model(k)) begin
        e.an[k] = 1'b0;
        e.seg   = DEC[m_dig[4*k +: 4]];
        e.dp    = ~m_dp[k];
      end
    end
    if (!rst_n || !enable) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_t   = 0;
      m_dig = digits_in; m_dp = dp_in; m_en = digit_en;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_dig = digits_in; m_dp = dp_in; m_en = digit_en;
      end
    end
    e.idx = m_act ? 2'((m_t / RD) % ND) : 2'd0;
    e.fd  = m_act && (m_t % FRAME == FRAME - 1);
    sbq.push_back(e);
  endtask

  task automatic tick();
    obs_t e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_total++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || scan_idx !== e.idx ||
          frame_done !== e.fd || $countones(~an) > 1) begin
        n_bad++;
        $display("FAIL scan @%0t: got an=%h seg=%h dp=%b idx=%0d fd=%b, want an=%h seg=%h dp=%b idx=%0d fd=%b",
                 $time, an, seg, dp, scan_idx, frame_done, e.an, e.seg, e.dp, e.idx, e.fd);
      end
    end
    pos = (pos + 1) % FRAME;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_fd();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      found = frame_done;
    end
    chk("frame_done_seen", 32'(found), 32'd1);
    pos = FRAME - 1;
  endtask

  task automatic goto_pos(input int t);
    while (pos != t) tick();
  endtask

  task automatic clear_model();
    m_act = 1'b0; m_t = 0; m_dig = '0; m_dp = '0; m_en = '0;
    sbq.delete();
  endtask

  task automatic run_vec(input int v);
    enable = 1'b1;
    digits_in = vecs[v].dig;
    dp_in = vecs[v].dpi;
    digit_en = vecs[v].en;
    wait_fd();
    for (int k = 0; k < ND; k++) begin
      goto_pos(RD * k + 1);
      chk($sformatf("v%0d_d%0d_guard_an", v, k), 32'(an), 32'hF);
      goto_pos(RD * k + 5);
      chk($sformatf("v%0d_d%0d_an", v, k), 32'(an), 32'(vecs[v].an_x[4*k +: 4]));
      chk($sformatf("v%0d_d%0d_seg", v, k), 32'(seg), 32'(vecs[v].seg_x[7*k +: 7]));
      chk($sformatf("v%0d_d%0d_dp", v, k), 32'(dp), 32'(vecs[v].dp_x[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    DEC = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'h3210, 4'h0, 4'hF, 16'h7BDE, {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF};
    vecs[1] = '{16'hFEDC, 4'h0, 4'hF, 16'h7BDE, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF};
    vecs[2] = '{16'h8765, 4'h1, 4'h5, 16'hFBFE, {7'h7F, 7'h78, 7'h7F, 7'h12}, 4'hE};
    vecs[3] = '{16'h9AB4, 4'hA, 4'hF, 16'h7BDE, {7'h10, 7'h08, 7'h03, 7'h19}, 4'h5};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[4] = '{16'h0700, 4'h0, 4'hF, 16'hFBDE, {7'h7F, 7'h78, 7'h40, 7'h40}, 4'hF};
    vecs[6] = '{16'h0000, 4'h2, 4'hF, 16'hFFDE, {7'h7F, 7'h7F, 7'h40, 7'h40}, 4'hD};
`else
    vecs[4] = '{16'h0700, 4'h0, 4'hF, 16'h7BDE, {7'h40, 7'h78, 7'h40, 7'h40}, 4'hF};
    vecs[6] = '{16'h0000, 4'h2, 4'hF, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hD};
`endif
    vecs[5] = '{16'h0700, 4'h8, 4'hF, 16'h7BDE, {7'h40, 7'h78, 7'h40, 7'h40}, 4'h7};

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_idx", 32'(scan_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    run_vec(0);

    // Mid-frame input change must not appear until the next frame.
    wait_fd();
    goto_pos(10);
    digits_in = 16'hFEDC;
    goto_pos(13);
    chk("coh_old_d1", 32'(seg), 32'h79);
    goto_pos(29);
    chk("coh_old_d3", 32'(seg), 32'h30);
    wait_fd();
    goto_pos(5);
    chk("coh_new_d0", 32'(seg), 32'h46);
    goto_pos(29);
    chk("coh_new_d3", 32'(seg), 32'h0E);

    for (int v = 1; v < 7; v++) run_vec(v);

    // Drop enable during digit 2, then restart from digit 0.
    digits_in = 16'h3210; dp_in = 4'h0; digit_en = 4'hF;
    wait_fd();
    goto_pos(19);
    chk("en_pre_an", 32'(an), 32'hB);
    enable = 1'b0;
    tick();
    chk("en_lag_an", 32'(an), 32'hB);
    chk("en_off_idx", 32'(scan_idx), 32'd0);
    tick();
    chk("en_off_an", 32'(an), 32'hF);
    chk("en_off_seg", 32'(seg), 32'h7F);
    chk("en_off_dp", 32'(dp), 32'd1);
    tick();
    enable = 1'b1;
    tick();
    chk("en_restart_idx", 32'(scan_idx), 32'd0);
    chk("en_restart_an", 32'(an), 32'hF);
    tick();
    tick();
    chk("en_restart_guard", 32'(an), 32'hF);
    tick();
    chk("en_restart_an_d0", 32'(an), 32'hE);
    chk("en_restart_seg_d0", 32'(seg), 32'h40);

    // Reset pulse between clock edges.
    wait_fd();
    goto_pos(13);
    chk("mid_pre_an", 32'(an), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    chk("mid_rst_idx", 32'(scan_idx), 32'd0);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    clear_model();
    repeat (4) tick();
    chk("post_rst_an_d0", 32'(an), 32'hE);
    chk("post_rst_seg_d0", 32'(seg), 32'h40);
    repeat (FRAME) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
